// File: rtl/grn_node_lut_pkg.sv
// Shared definitions for the GRN node.
// Contents:
//   - integer clog2 and the counter-width helper (minimum width 1)
//   - LUT width helper (1 << N_IN)
//   - legal-range checks for N_IN and SLOW_DIV
//   - OR-function truth-table builder
// No ports; this file is imported by grn_slow_div and grn_node_lut.
package grn_node_lut_pkg;

   localparam int N_IN_MIN     = 1;
   localparam int N_IN_MAX     = 6;
   localparam int SLOW_DIV_MIN = 1;
   localparam int SLOW_DIV_MAX = 16;
   localparam int LUT_MAX_W    = 1 << N_IN_MAX;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // A divide-by-1 counter still needs one bit to exist.
   function automatic int cnt_w(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

   function automatic int lut_w(input int n);
      return 1 << n;
   endfunction

   function automatic bit n_in_legal(input int n);
      return (n >= N_IN_MIN) && (n <= N_IN_MAX);
   endfunction

   function automatic bit slow_div_legal(input int d);
      return (d >= SLOW_DIV_MIN) && (d <= SLOW_DIV_MAX);
   endfunction

   // Truth table of the OR of n inputs: every index except 0 yields 1.
   function automatic logic [LUT_MAX_W-1:0] or_lut(input int n);
      logic [LUT_MAX_W-1:0] t;
      t = '0;
      for (int i = 1; i < LUT_MAX_W; i++) begin
         if (i < (1 << n)) t[i] = 1'b1;
      end
      return t;
   endfunction

endpackage

// File: rtl/grn_slow_div.sv
// Divider that paces the slow (tortoise) copy of a GRN node.
// Ports:
//   clk      system clock
//   rst      synchronous active-low reset, count -> 0
//   load_max preload the terminal count so the next step fires
//   step     count request (one slow-copy start)
//   fire     step arrives while the count is at its terminal value
module grn_slow_div
   import grn_node_lut_pkg::*;
#(
   parameter int SLOW_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_max,
   input  logic step,
   output logic fire
);

   localparam int            CW  = cnt_w(SLOW_DIV);
   localparam logic [CW-1:0] MAX = CW'(SLOW_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_at_max;

   assign w_at_max = (r_cnt == MAX);
   assign fire     = step & w_at_max;

   // Terminal value returns to zero instead of wrapping, so the count
   // never leaves 0..SLOW_DIV-1 (and stays at 0 for SLOW_DIV = 1).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (load_max) begin
         r_cnt <= MAX;
      end else if (step) begin
         r_cnt <= w_at_max ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/grn_node_lut.sv
// Two-copy Boolean GRN node with a programmable regulation truth table.
// s0 (slow copy) updates once every SLOW_DIV start_s0 pulses, s1 (fast
// copy) on every start_s1. Force mode overrides the table output.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   reset_nos         load init_state into both copies (re-seed)
//   start_s0/start_s1 slow / fast copy step requests
//   init_state        seed value for reset_nos
//   in_s0/in_s1       regulator states, bit i = regulator i
//   cfg_we/cfg_din    truth-table write strobe and data
//   force_en/force_val knockout / overexpression control
//   s0/s1             registered copies; node_s0/node_s1 fan-out copies
//   eq                s0 == s1, for the global attractor detector
//   lut_q             current truth table
module grn_node_lut
   import grn_node_lut_pkg::*;
#(
   parameter int                       N_IN     = 2,
   parameter int                       SLOW_DIV = 2,
   parameter logic [(1 << N_IN) - 1:0] INIT_LUT = {{((1 << N_IN) - 1){1'b1}}, 1'b0}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    reset_nos,
   input  logic                    start_s0,
   input  logic                    start_s1,
   input  logic                    init_state,
   input  logic [N_IN-1:0]         in_s0,
   input  logic [N_IN-1:0]         in_s1,
   input  logic                    cfg_we,
   input  logic [lut_w(N_IN)-1:0]  cfg_din,
   input  logic                    force_en,
   input  logic                    force_val,
   output logic                    s0,
   output logic                    s1,
   output logic                    node_s0,
   output logic                    node_s1,
   output logic                    eq,
   output logic [lut_w(N_IN)-1:0]  lut_q
);

   if (!n_in_legal(N_IN)) begin : g_bad_n_in
      $error("grn_node_lut: N_IN must be within 1..6");
   end
   if (!slow_div_legal(SLOW_DIV)) begin : g_bad_slow_div
      $error("grn_node_lut: SLOW_DIV must be within 1..16");
   end

   logic [lut_w(N_IN)-1:0] r_lut;
   logic                   r_s0;
   logic                   r_s1;
   logic                   w_f0;
   logic                   w_f1;
   logic                   w_fire0;
   logic                   w_step0;

   // Re-seed swallows any start in the same cycle, so the divider only
   // sees a step when reset_nos is low.
   assign w_step0 = start_s0 & ~reset_nos;

   grn_slow_div #(
      .SLOW_DIV (SLOW_DIV)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .load_max (reset_nos),
      .step     (w_step0),
      .fire     (w_fire0)
   );

   // Both evaluations read r_lut, i.e. the table in force before any
   // write landing on this same edge.
   assign w_f0 = force_en ? force_val : r_lut[in_s0];
   assign w_f1 = force_en ? force_val : r_lut[in_s1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lut <= INIT_LUT;
         r_s0  <= 1'b0;
         r_s1  <= 1'b0;
      end else begin
         if (cfg_we) r_lut <= cfg_din;
         if (reset_nos) begin
            r_s0 <= init_state;
            r_s1 <= init_state;
         end else begin
            if (w_fire0)  r_s0 <= w_f0;
            if (start_s1) r_s1 <= w_f1;
         end
      end
   end

   assign s0      = r_s0;
   assign s1      = r_s1;
   assign node_s0 = r_s0;
   assign node_s1 = r_s1;
   assign eq      = (r_s0 == r_s1);
   assign lut_q   = r_lut;

endmodule
